// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-buffered UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state and an even-parity helper.
package uart_tx_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

    function automatic logic even_parity(input logic [DATA_BITS-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and a combinational head word.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Push on a full FIFO is dropped even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter with a per-frame programmable bit period.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between DATA and STOP.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_t state;
    tx_state_t next_state;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 push_ok;
    logic                 pop;
    logic                 bit_done;

    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DIV_W-1:0]     bit_len_q;
    logic [DIV_W-1:0]     bit_len_d;
    logic [DIV_W-1:0]     cycle_q;
    logic [DIV_W-1:0]     cycle_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
    logic                 parity_d;
`endif

    logic                 ser_tx_d;
    logic                 busy_d;

    assign in_ready = !fifo_full;
    assign push_ok  = in_valid && in_ready;
    assign bit_done = (cycle_q == bit_len_q);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (wb_clk_i),
        .reset (wb_rst_i),
        .push  (push_ok),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // STOP chains straight into START when another byte is waiting.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) next_state = START;
            end
            START: begin
                if (bit_done) next_state = DATA;
            end
            DATA: begin
                if (bit_done && (bit_idx_q == IDX_W'(DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) next_state = STOP;
            end
`endif
            STOP: begin
                if (bit_done) next_state = fifo_empty ? IDLE : START;
            end
            default: next_state = IDLE;
        endcase
    end

    // The line register is loaded with the level of the state being entered,
    // so ser_tx stays registered without lagging the state by a cycle.
    always_comb begin
        pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
        ser_tx_d = IDLE_LEVEL;
        case (next_state)
            START:   ser_tx_d = 1'b0;
            DATA:    ser_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  ser_tx_d = parity_q;
`endif
            default: ser_tx_d = IDLE_LEVEL;
        endcase
        busy_d = (next_state != IDLE) || !fifo_empty || push_ok;
    end

    always_comb begin
        shift_d   = shift_q;
        bit_len_d = bit_len_q;
        bit_idx_d = bit_idx_q;
        cycle_d   = bit_done ? '0 : cycle_q + DIV_W'(1);
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state == IDLE) begin
            cycle_d = '0;
        end
        if (pop) begin
            shift_d   = fifo_head;
            bit_len_d = clk_div;
            bit_idx_d = '0;
            cycle_d   = '0;
`ifdef UART_TX_PARITY_EN
            parity_d  = even_parity(fifo_head);
`endif
        end else if ((state == DATA) && bit_done) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shift_q   <= '0;
            bit_len_q <= '0;
            cycle_q   <= '0;
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
            ser_tx    <= IDLE_LEVEL;
            busy      <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_len_q <= bit_len_d;
            cycle_q   <= cycle_d;
            bit_idx_q <= bit_idx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            ser_tx    <= ser_tx_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

FIFO-buffered 8N1 UART transmitter for the user project area. Lets user logic or firmware (through a Wishbone/LA bridge) stream bytes to the testbench UART monitor on mprj_io[6]. Bytes are accepted on a valid/ready byte interface, buffered, and serialized LSB-first at a runtime-programmable bit period.

## Interface
- FIFO_DEPTH, 8: byte FIFO entries; power of two, minimum 2.
- DIV_W, 16: width of the bit-period divisor.
- wb_clk_i  input  1: sole clock; all logic on rising edge.
- wb_rst_i  input  1: synchronous, active-high reset.
- clk_div  input  DIV_W: bit period minus one, in wb_clk_i cycles; sampled at each start bit.
- in_data  input  8: byte to transmit.
- in_valid  input  1: in_data is valid.
- in_ready  output  1: FIFO can accept a byte; equals (count < FIFO_DEPTH) from registered count.
- ser_tx  output  1: serial line; idles high.
- busy  output  1: high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push: a byte is accepted on any cycle where in_valid && in_ready. Writes while full are ignored; no overflow flag.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: ser_tx=1. If FIFO is non-empty: pop the head into shift register, latch clk_div into bit_len, clear bit counter, go to START.
- START: ser_tx=0 for bit_len+1 cycles, then DATA.
- DATA: ser_tx=shift[0]; after each bit period, shift right. After 8 bits go to PARITY or STOP.
- STOP: ser_tx=1 for bit_len+1 cycles. In the last STOP cycle: if FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Divisor: clk_div=0 yields a 1-cycle bit. Changing clk_div mid-frame has no effect until the next start bit.
- Simultaneous push and pop: both occur; count is unchanged. Push on a full FIFO is rejected even if a pop occurs in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

## Timing
- Reset values: ser_tx=1, busy=0, in_ready=1, fifo_count=0, state IDLE, FIFO pointers 0.
- Reset mid-frame: ser_tx=1 on the cycle after wb_rst_i is sampled high. FIFO contents are discarded.
- Latency: a byte pushed at cycle N into an empty FIFO while IDLE gives count=1 at N+1; the pop occurs at N+1; ser_tx falls at N+2.
- Frame length: 10*(clk_div+1) cycles, or 11*(clk_div+1) with parity.
- busy rises the cycle after the first accepted push. It falls the cycle after the final STOP bit completes with an empty FIFO.
- All outputs are registered except in_ready, which is derived only from registered count.

## Configuration
- UART_TX_PARITY_EN: when defined, PARITY state inserts one even-parity bit (XOR of the 8 data bits) between DATA and STOP.
- Without the macro, frames are strict 8N1 and the PARITY state does not exist.

## Structure
- Package uart_tx_pkg: state enum (IDLE, START, DATA, PARITY, STOP), DATA_BITS=8, IDLE_LEVEL=1'b1.
- Sub-module sync_fifo (parameterized width/depth, registered count, push/pop/full/empty) holds the byte buffer. The FSM and baud counter live in uart_tx_fifo.

## Test plan
- clk_div=3, push 0xA5 once -> ser_tx low at push+2 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; busy falls 1 cycle later.
- Push 0x00 then 0xFF back-to-back, clk_div=0 -> 20 contiguous bit cycles with no idle gap between the STOP of byte 1 and the START of byte 2.
- Push 9 bytes with FIFO_DEPTH=8 while line is busy -> in_ready low at count=8, 9th byte dropped, exactly 8+1 frames sent, fifo_count returns to 0.
- Assert wb_rst_i for 1 cycle during DATA bit 3 with 3 bytes queued -> ser_tx=1 next cycle, fifo_count=0, no further frames.
- Change clk_div 3->7 during a frame -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
- With UART_TX_PARITY_EN, push 0x07 -> parity bit 1 precedes STOP; frame length 11*(clk_div+1).
